pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline-stage register, the successor to the fixed E→M latch. It carries an opaque payload plus the hazard-relevant fields (destination register, write enable, Tnew) between any two stages. A valid/ready handshake and a 2-entry skid buffer give full throughput with a fully registered `in_ready`. It also adds flush-to-bubble and a per-stage saturating Tnew decrement, so the hazard unit reads correct Tnew/A3 from every stage instance.

---
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and a registered in_ready.
// Carries an opaque payload plus destination register, regwrite and Tnew for the hazard unit.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_a3,
    input  logic              in_regwrite,
    input  logic [TNEW_W-1:0] in_tnew,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_a3,
    output logic              out_regwrite,
    output logic [TNEW_W-1:0] out_tnew
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [REG_W-1:0]  main_a3_q, main_a3_d;
    logic              main_rw_q, main_rw_d;
    logic [TNEW_W-1:0] main_tnew_q, main_tnew_d;

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [REG_W-1:0]  skid_a3_q, skid_a3_d;
    logic              skid_rw_q, skid_rw_d;
    logic [TNEW_W-1:0] skid_tnew_q, skid_tnew_d;

    logic              push;
    logic              pop;
    logic [TNEW_W-1:0] cap_tnew;

    // Registered ready: depends only on skid state, never on out_ready.
    assign in_ready = ~skid_valid_q;
    assign push     = in_valid & in_ready;
    assign pop      = main_valid_q & out_ready;

    // Tnew decrements exactly once, at capture, saturating at zero.
    assign cap_tnew = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_a3_d    = main_a3_q;
        main_rw_d    = main_rw_q;
        main_tnew_d  = main_tnew_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_a3_d    = skid_a3_q;
        skid_rw_d    = skid_rw_q;
        skid_tnew_d  = skid_tnew_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (push) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_a3_d    = in_a3;
                main_rw_d    = in_regwrite;
                main_tnew_d  = cap_tnew;
            end
        end else if (!skid_valid_q) begin
            if (push && pop) begin
                main_data_d = in_data;
                main_a3_d   = in_a3;
                main_rw_d   = in_regwrite;
                main_tnew_d = cap_tnew;
            end else if (push) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_a3_d    = in_a3;
                skid_rw_d    = in_regwrite;
                skid_tnew_d  = cap_tnew;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
        end else if (pop) begin
            // Skid moves up unchanged; in_ready is low so no push can race it.
            main_data_d  = skid_data_q;
            main_a3_d    = skid_a3_q;
            main_rw_d    = skid_rw_q;
            main_tnew_d  = skid_tnew_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_a3_q    <= '0;
            main_rw_q    <= 1'b0;
            main_tnew_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_a3_q    <= '0;
            skid_rw_q    <= 1'b0;
            skid_tnew_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_a3_q    <= main_a3_d;
            main_rw_q    <= main_rw_d;
            main_tnew_q  <= main_tnew_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_a3_q    <= skid_a3_d;
            skid_rw_q    <= skid_rw_d;
            skid_tnew_q  <= skid_tnew_d;
        end
    end

    // Bubbles present no destination, so they can never raise a false hazard.
    assign out_valid    = main_valid_q;
    assign out_data     = main_data_q;
    assign out_a3       = main_valid_q ? main_a3_q : '0;
    assign out_regwrite = main_valid_q & main_rw_q;
    assign out_tnew     = main_valid_q ? main_tnew_q : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: inputs change 1 time unit after posedge,
// outputs are sampled there too (they depend on registered state only).
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [REG_W-1:0]  in_a3;
    logic              in_regwrite;
    logic [TNEW_W-1:0] in_tnew;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [REG_W-1:0]  out_a3;
    logic              out_regwrite;
    logic [TNEW_W-1:0] out_tnew;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .TNEW_W (TNEW_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_a3        (in_a3),
        .in_regwrite  (in_regwrite),
        .in_tnew      (in_tnew),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_a3       (out_a3),
        .out_regwrite (out_regwrite),
        .out_tnew     (out_tnew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [REG_W-1:0] a3,
                         input logic rw, input logic [TNEW_W-1:0] tn);
        in_valid    = v;
        in_data     = d;
        in_a3       = a3;
        in_regwrite = rw;
        in_tnew     = tn;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 128'h99, 5'd7, 1'b1, 2'd3);

        // Reset held 2 cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", out_valid, 1'b0);
            check("rst_ready", in_ready, 1'b1);
            check("rst_a3", out_a3, 0);
            check("rst_tnew", out_tnew, 0);
            check("rst_rw", out_regwrite, 1'b0);
            check("rst_data", out_data, 0);
        end

        reset = 1'b0;
        drive(1'b1, 128'h5, 5'd3, 1'b1, 2'd2);
        tick();
        check("first_valid", out_valid, 1'b1);
        check("first_data", out_data, 128'h5);
        check("first_a3", out_a3, 5'd3);
        check("first_tnew", out_tnew, 2'd1);
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        check("first_drain", out_valid, 1'b0);

        // Streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), 5'd1, 1'b1, 2'd2);
            check("stream_ready", in_ready, 1'b1);
            tick();
            check("stream_valid", out_valid, 1'b1);
            check("stream_data", out_data, DATA_W'(i));
            check("stream_tnew", out_tnew, 2'd1);
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        check("stream_end", out_valid, 1'b0);

        // Tnew saturation and hold
        out_ready = 1'b0;
        drive(1'b1, 128'h10, 5'd2, 1'b1, 2'd0);
        tick();
        check("sat_tnew0", out_tnew, 2'd0);
        out_ready = 1'b1;
        drive(1'b1, 128'h11, 5'd2, 1'b1, 2'd3);
        tick();
        check("sat_data", out_data, 128'h11);
        check("sat_tnew3", out_tnew, 2'd2);
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_tnew", out_tnew, 2'd2);
            check("hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        check("sat_drain", out_valid, 1'b0);

        // Skid and backpressure: A, B, C
        out_ready = 1'b0;
        drive(1'b1, 128'hA, 5'd10, 1'b1, 2'd2);
        tick();
        check("skid_a_data", out_data, 128'hA);
        check("skid_a_ready", in_ready, 1'b1);
        drive(1'b1, 128'hB, 5'd11, 1'b1, 2'd3);
        tick();
        check("skid_b_hold", out_data, 128'hA);
        check("skid_b_ready", in_ready, 1'b0);
        drive(1'b1, 128'hC, 5'd12, 1'b1, 2'd1);
        tick();
        check("skid_c_hold", out_data, 128'hA);
        check("skid_c_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        check("deliver_b", out_data, 128'hB);
        check("deliver_b_tnew", out_tnew, 2'd2);
        check("deliver_b_a3", out_a3, 5'd11);
        check("recover_ready", in_ready, 1'b1);
        tick();
        check("deliver_c", out_data, 128'hC);
        check("deliver_c_tnew", out_tnew, 2'd0);
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        check("skid_drain", out_valid, 1'b0);

        // Flush with both entries full plus a pending D
        out_ready = 1'b0;
        drive(1'b1, 128'hE, 5'd4, 1'b1, 2'd1);
        tick();
        drive(1'b1, 128'hF, 5'd5, 1'b1, 2'd1);
        tick();
        check("pre_flush_ready", in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 128'hD, 5'd6, 1'b1, 2'd1);
        tick();
        check("flush_valid", out_valid, 1'b0);
        check("flush_rw", out_regwrite, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        out_ready = 1'b1;
        tick();
        check("flush_no_d", out_valid, 1'b0);

        // Flush with main only: a concurrent accepted push must be discarded
        out_ready = 1'b0;
        drive(1'b1, 128'h6, 5'd6, 1'b1, 2'd1);
        tick();
        flush = 1'b1;
        drive(1'b1, 128'hD, 5'd6, 1'b1, 2'd1);
        tick();
        check("flush2_valid", out_valid, 1'b0);
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        check("flush2_no_d", out_valid, 1'b0);
        check("flush2_a3", out_a3, 0);

        // Bubble gating after a pop
        out_ready = 1'b1;
        drive(1'b1, 128'h77, 5'd31, 1'b1, 2'd3);
        tick();
        check("bub_a3", out_a3, 5'd31);
        check("bub_rw", out_regwrite, 1'b1);
        check("bub_tnew", out_tnew, 2'd2);
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        check("bub_valid0", out_valid, 1'b0);
        check("bub_a3_0", out_a3, 0);
        check("bub_rw_0", out_regwrite, 1'b0);
        check("bub_tnew_0", out_tnew, 0);
        check("bub_data_hold", out_data, 128'h77);

        // Mid-operation reset with both entries full
        out_ready = 1'b0;
        drive(1'b1, 128'h21, 5'd1, 1'b1, 2'd2);
        tick();
        drive(1'b1, 128'h22, 5'd2, 1'b1, 2'd2);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        check("midrst_data", out_data, 0);
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        check("midrst_empty", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
